// File: rtl/sdram_init_seq_if.sv
// Start/status and command-bus bundle between the init sequencer and its requester.
// init_bus = {cmd[3:0], a[ROW_W-1:0], ba[BA_W-1:0], cke}.
interface sdram_init_seq_if #(
    parameter int ROW_W = 13,
    parameter int BA_W  = 2
);
    logic                    init_en;
    logic                    init_busy;
    logic                    init_done;
    logic [7:0]              ref_left;
    logic [ROW_W+BA_W+4:0]   init_bus;

    modport master (
        output init_en,
        input  init_busy,
        input  init_done,
        input  ref_left,
        input  init_bus
    );

    modport slave (
        input  init_en,
        output init_busy,
        output init_done,
        output ref_left,
        output init_bus
    );
endinterface

// File: rtl/sdram_init_seq.sv
// Parametrised SDRAM power-up init sequencer: power wait, CKE, PRE-all, NUM_REF x REF, LMR.
// Optional extended mode register load enabled by defining SDRAM_INIT_EMR_EN.
module sdram_init_seq #(
    parameter int         ROW_W      = 13,
    parameter int         BA_W       = 2,
    parameter int         CNT_W      = 16,
    parameter int         T_PWR      = 10000,
    parameter int         T_RP       = 2,
    parameter int         T_RFC      = 7,
    parameter int         T_MRD      = 2,
    parameter int         NUM_REF    = 2,
    parameter logic [2:0] BL_CODE    = 3'b011,
    parameter logic       BURST_TYPE = 1'b0,
    parameter logic [2:0] CAS_LAT    = 3'b011,
    parameter logic       WB_MODE    = 1'b0
`ifdef SDRAM_INIT_EMR_EN
    ,
    parameter logic [ROW_W-1:0] EMR_VAL = '0
`endif
) (
    input  logic              clk,
    input  logic              soft_rst,
    sdram_init_seq_if.slave   bus
);

    localparam logic [3:0] CMD_INH = 4'b1111;
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;

    localparam logic [CNT_W:0] C_ONE = (CNT_W+1)'(1);
    localparam logic [CNT_W:0] C_TWO = (CNT_W+1)'(2);
    localparam logic [CNT_W:0] PWR_L = (CNT_W+1)'(T_PWR);
    localparam logic [CNT_W:0] RP_L  = (CNT_W+1)'(T_RP);
    localparam logic [CNT_W:0] RFC_L = (CNT_W+1)'(T_RFC);
    localparam logic [CNT_W:0] MRD_L = (CNT_W+1)'(T_MRD);

    localparam logic [ROW_W-1:0] A10_ONLY  = ROW_W'(11'h400);
    localparam logic [ROW_W-1:0] MODE_WORD = ROW_W'({WB_MODE, 2'b00, CAS_LAT, BURST_TYPE, BL_CODE});

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_PWR,
        S_CKE_UP,
        S_PRE,
        S_WAIT_RP,
        S_REF,
        S_WAIT_RFC,
        S_LMR,
        S_WAIT_MRD
`ifdef SDRAM_INIT_EMR_EN
        ,
        S_EMR,
        S_WAIT_EMR
`endif
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_cmd;
    logic [ROW_W-1:0]   r_a;
    logic [BA_W-1:0]    r_ba;
    logic               r_cke;
    logic               r_busy;
    logic               r_done;
    logic [7:0]         r_refLeft;

    logic [CNT_W:0]     w_lim;
    logic               w_inCmd;
    logic               w_spaceDone;
    logic               w_pwrDone;

    // Spacing is measured from the command cycle; a limit of 1 skips the wait state entirely.
    always_comb begin
        w_lim   = RP_L;
        w_inCmd = 1'b0;
        case (r_state)
            S_PRE:                   begin w_lim = RP_L;  w_inCmd = 1'b1; end
            S_REF:                   begin w_lim = RFC_L; w_inCmd = 1'b1; end
            S_WAIT_RFC:              w_lim = RFC_L;
            S_LMR:                   begin w_lim = MRD_L; w_inCmd = 1'b1; end
            S_WAIT_MRD:              w_lim = MRD_L;
`ifdef SDRAM_INIT_EMR_EN
            S_EMR:                   begin w_lim = MRD_L; w_inCmd = 1'b1; end
            S_WAIT_EMR:              w_lim = MRD_L;
`endif
            default:                 w_lim = RP_L;
        endcase
        w_spaceDone = w_inCmd ? (w_lim <= C_ONE) : (({1'b0, r_cnt} + C_TWO) >= w_lim);
        w_pwrDone   = (({1'b0, r_cnt} + C_ONE) >= PWR_L);
    end

    always_ff @(posedge clk) begin
        if (soft_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_cmd     <= CMD_INH;
            r_a       <= '0;
            r_ba      <= '0;
            r_cke     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_refLeft <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.init_en) begin
                        r_state   <= S_WAIT_PWR;
                        r_cnt     <= '0;
                        r_cmd     <= CMD_INH;
                        r_cke     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_refLeft <= 8'(NUM_REF);
                    end
                end
                S_WAIT_PWR: begin
                    if (w_pwrDone) begin
                        r_state <= S_CKE_UP;
                        r_cnt   <= '0;
                        r_cmd   <= CMD_NOP;
                        r_cke   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_CKE_UP: begin
                    r_state <= S_PRE;
                    r_cnt   <= '0;
                    r_cmd   <= CMD_PRE;
                    r_a     <= A10_ONLY;
                    r_ba    <= '0;
                end
                S_PRE, S_WAIT_RP: begin
                    if (w_spaceDone) begin
                        r_state   <= S_REF;
                        r_cnt     <= '0;
                        r_cmd     <= CMD_REF;
                        r_refLeft <= r_refLeft - 8'd1;
                    end else if (r_state == S_PRE) begin
                        r_state <= S_WAIT_RP;
                        r_cnt   <= '0;
                        r_cmd   <= CMD_NOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_REF, S_WAIT_RFC: begin
                    if (w_spaceDone) begin
                        r_cnt <= '0;
                        if (r_refLeft != 8'd0) begin
                            r_state   <= S_REF;
                            r_cmd     <= CMD_REF;
                            r_refLeft <= r_refLeft - 8'd1;
                        end else begin
                            r_state <= S_LMR;
                            r_cmd   <= CMD_LMR;
                            r_a     <= MODE_WORD;
                            r_ba    <= '0;
                        end
                    end else if (r_state == S_REF) begin
                        r_state <= S_WAIT_RFC;
                        r_cnt   <= '0;
                        r_cmd   <= CMD_NOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_LMR, S_WAIT_MRD: begin
                    if (w_spaceDone) begin
                        r_cnt <= '0;
`ifdef SDRAM_INIT_EMR_EN
                        r_state <= S_EMR;
                        r_cmd   <= CMD_LMR;
                        r_a     <= EMR_VAL;
                        r_ba    <= BA_W'(1);
`else
                        r_state <= S_IDLE;
                        r_cmd   <= CMD_NOP;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
`endif
                    end else if (r_state == S_LMR) begin
                        r_state <= S_WAIT_MRD;
                        r_cnt   <= '0;
                        r_cmd   <= CMD_NOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`ifdef SDRAM_INIT_EMR_EN
                S_EMR, S_WAIT_EMR: begin
                    if (w_spaceDone) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_cmd   <= CMD_NOP;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_state == S_EMR) begin
                        r_state <= S_WAIT_EMR;
                        r_cnt   <= '0;
                        r_cmd   <= CMD_NOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`endif
                default: begin
                    r_state   <= S_IDLE;
                    r_cnt     <= '0;
                    r_cmd     <= CMD_INH;
                    r_a       <= '0;
                    r_ba      <= '0;
                    r_cke     <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    r_refLeft <= '0;
                end
            endcase
        end
    end

    assign bus.init_busy = r_busy;
    assign bus.init_done = r_done;
    assign bus.ref_left  = r_refLeft;
    assign bus.init_bus  = {r_cmd, r_a, r_ba, r_cke};

endmodule

// File: tb/tb_sdram_init_seq.sv
// Directed bench for sdram_init_seq: reset, full runs, ignored start, abort, re-init, minimum timings.
// Honours SDRAM_INIT_EMR_EN when the design is built with it.
module tb_sdram_init_seq;

    localparam logic [3:0] CMD_INH = 4'b1111;
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;

    localparam logic [12:0] MODE_A  = 13'h032;
    localparam logic [12:0] MODE_B  = 13'h033;
`ifdef SDRAM_INIT_EMR_EN
    localparam int          DONE_A  = 43;
    localparam int          DONE_B  = 8;
    localparam logic [12:0] FINAL_A = 13'h020;
    localparam logic [1:0]  FINAL_BA = 2'd1;
`else
    localparam int          DONE_A  = 41;
    localparam int          DONE_B  = 7;
    localparam logic [12:0] FINAL_A = 13'h032;
    localparam logic [1:0]  FINAL_BA = 2'd0;
`endif

    logic clk;
    logic soft_rst;
    int   checks;
    int   failures;
    logic [12:0] heldA;
    logic [1:0]  heldBa;

    sdram_init_seq_if #(.ROW_W(13), .BA_W(2)) ifA ();
    sdram_init_seq_if #(.ROW_W(13), .BA_W(2)) ifB ();

    sdram_init_seq #(
        .T_PWR(20), .T_RP(3), .T_RFC(7), .T_MRD(2), .NUM_REF(2), .BL_CODE(3'b010)
`ifdef SDRAM_INIT_EMR_EN
        , .EMR_VAL(13'h020)
`endif
    ) dutA (
        .clk      (clk),
        .soft_rst (soft_rst),
        .bus      (ifA.slave)
    );

    sdram_init_seq #(
        .T_PWR(2), .T_RP(1), .T_RFC(1), .T_MRD(1), .NUM_REF(1)
`ifdef SDRAM_INIT_EMR_EN
        , .EMR_VAL(13'h155)
`endif
    ) dutB (
        .clk      (clk),
        .soft_rst (soft_rst),
        .bus      (ifB.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Hand-derived command timeline for instance A, cycle 1 = first cycle after the start sample.
    function automatic logic [3:0] expCmdA(input int c);
        if (c <= 20)                 return CMD_INH;
        if (c == 22)                 return CMD_PRE;
        if (c == 25 || c == 32)      return CMD_REF;
        if (c == 39)                 return CMD_LMR;
`ifdef SDRAM_INIT_EMR_EN
        if (c == 41)                 return CMD_LMR;
`endif
        return CMD_NOP;
    endfunction

    function automatic logic [3:0] expCmdB(input int c);
        if (c <= 2)                  return CMD_INH;
        if (c == 4)                  return CMD_PRE;
        if (c == 5)                  return CMD_REF;
        if (c == 6)                  return CMD_LMR;
`ifdef SDRAM_INIT_EMR_EN
        if (c == 7)                  return CMD_LMR;
`endif
        return CMD_NOP;
    endfunction

    // Called at a falling edge; drives a start request and checks A every cycle of the run.
    task automatic applyStimulus(input int injectAt, input int abortAt);
        int last;
        last = (abortAt > 0) ? abortAt : DONE_A + 1;
        ifA.init_en = 1'b1;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c == 1) ifA.init_en = 1'b0;
            if (c == injectAt) ifA.init_en = 1'b1;
            if (c == injectAt + 1) ifA.init_en = 1'b0;
            checkOutput($sformatf("cmd@%0d", c), 32'(ifA.init_bus[19:16]), 32'(expCmdA(c)));
            checkOutput($sformatf("cke@%0d", c), 32'(ifA.init_bus[0]), 32'(c >= 21));
            checkOutput($sformatf("busy@%0d", c), 32'(ifA.init_busy), 32'(c < DONE_A));
            checkOutput($sformatf("done@%0d", c), 32'(ifA.init_done), 32'(c >= DONE_A));
            checkOutput($sformatf("refLeft@%0d", c), 32'(ifA.ref_left), (c <= 24) ? 32'd2 : (c <= 31) ? 32'd1 : 32'd0);
            if (c == 1) begin
                checkOutput("aHeld", 32'(ifA.init_bus[15:3]), 32'(heldA));
                checkOutput("baHeld", 32'(ifA.init_bus[2:1]), 32'(heldBa));
            end
            if (c == 22) begin
                checkOutput("preA", 32'(ifA.init_bus[15:3]), 32'h400);
                checkOutput("preBa", 32'(ifA.init_bus[2:1]), 32'd0);
            end
            if (c == 39) begin
                checkOutput("lmrA", 32'(ifA.init_bus[15:3]), 32'(MODE_A));
                checkOutput("lmrBa", 32'(ifA.init_bus[2:1]), 32'd0);
            end
            if (c == DONE_A) begin
                checkOutput("doneA", 32'(ifA.init_bus[15:3]), 32'(FINAL_A));
                checkOutput("doneBa", 32'(ifA.init_bus[2:1]), 32'(FINAL_BA));
            end
            if (c == abortAt) soft_rst = 1'b1;
        end
        if (abortAt == 0) begin
            heldA  = FINAL_A;
            heldBa = FINAL_BA;
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        heldA        = '0;
        heldBa       = '0;
        soft_rst     = 1'b1;
        ifA.init_en  = 1'b0;
        ifB.init_en  = 1'b0;

        repeat (5) @(negedge clk);
        checkOutput("rstBus", 32'(ifA.init_bus), 32'h000F0000);
        checkOutput("rstBusy", 32'(ifA.init_busy), 32'd0);
        checkOutput("rstDone", 32'(ifA.init_done), 32'd0);
        checkOutput("rstRefLeft", 32'(ifA.ref_left), 32'd0);
        checkOutput("rstBusB", 32'(ifB.init_bus), 32'h000F0000);
        soft_rst = 1'b0;
        @(negedge clk);
        checkOutput("idleBus", 32'(ifA.init_bus), 32'h000F0000);

        $display("[TB] basic run");
        applyStimulus(0, 0);
        $display("[TB] re-init after done");
        applyStimulus(0, 0);
        $display("[TB] start pulse while busy");
        applyStimulus(23, 0);

        $display("[TB] abort in WAIT_RFC");
        applyStimulus(0, 30);
        @(negedge clk);
        soft_rst = 1'b0;
        heldA    = '0;
        heldBa   = '0;
        checkOutput("abortBus", 32'(ifA.init_bus), 32'h000F0000);
        checkOutput("abortBusy", 32'(ifA.init_busy), 32'd0);
        checkOutput("abortDone", 32'(ifA.init_done), 32'd0);
        checkOutput("abortRefLeft", 32'(ifA.ref_left), 32'd0);
        for (int c = 32; c <= 35; c++) begin
            @(negedge clk);
            checkOutput($sformatf("abortIdle@%0d", c), 32'(ifA.init_bus), 32'h000F0000);
        end
        applyStimulus(0, 0);

        $display("[TB] minimum timings, single refresh");
        ifB.init_en = 1'b1;
        for (int c = 1; c <= DONE_B + 1; c++) begin
            @(negedge clk);
            if (c == 1) ifB.init_en = 1'b0;
            checkOutput($sformatf("bCmd@%0d", c), 32'(ifB.init_bus[19:16]), 32'(expCmdB(c)));
            checkOutput($sformatf("bCke@%0d", c), 32'(ifB.init_bus[0]), 32'(c >= 3));
            checkOutput($sformatf("bBusy@%0d", c), 32'(ifB.init_busy), 32'(c < DONE_B));
            checkOutput($sformatf("bDone@%0d", c), 32'(ifB.init_done), 32'(c >= DONE_B));
            checkOutput($sformatf("bRefLeft@%0d", c), 32'(ifB.ref_left), (c <= 4) ? 32'd1 : 32'd0);
            if (c == 6) checkOutput("bLmrA", 32'(ifB.init_bus[15:3]), 32'(MODE_B));
`ifdef SDRAM_INIT_EMR_EN
            if (c == 7) begin
                checkOutput("bEmrA", 32'(ifB.init_bus[15:3]), 32'h155);
                checkOutput("bEmrBa", 32'(ifB.init_bus[2:1]), 32'd1);
            end
`endif
        end
        checkOutput("aQuiet", 32'(ifA.init_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
